event_seq_checker: RTL and testbench

Cycle-driven event sequencer and completion checker for the timing-regression designs. After `start`, it counts clock cycles and fires two event-request pulses at programmed cycle numbers. It collects the acknowledgements returned by the downstream event handlers and issues a single pass/fail verdict at a programmed check cycle. It is the upstream stage that drives the per-event handler blocks and audits their `triggered` flags.

---
 rtl/event_seq_checker.sv | 107 ++++++++++
 tb/tb_event_seq_checker.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/event_seq_checker.sv
// Cycle-driven event sequencer: fires two request pulses at fixed run cycles, collects the
// handler acknowledgements and registers a single pass/fail verdict at the check cycle.
module event_seq_checker #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned E1_CYC    = 2,
  parameter int unsigned E2_CYC    = 3,
  parameter int unsigned CHECK_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ack_e1,
  input  logic             ack_e2,
  output logic             fire_e1,
  output logic             fire_e2,
  output logic [CNT_W-1:0] cyc,
  output logic [1:0]       triggered,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_cause
);

  localparam logic [CNT_W-1:0] E1  = CNT_W'(E1_CYC);
  localparam logic [CNT_W-1:0] E2  = CNT_W'(E2_CYC);
  localparam logic [CNT_W-1:0] CHK = CNT_W'(CHECK_CYC);

  localparam logic [1:0] CauseNone     = 2'b00;
  localparam logic [1:0] CauseSpurious = 2'b01;
  localparam logic [1:0] CauseMissing  = 2'b10;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cyc_inc;
  logic [1:0]       ack;
  logic [1:0]       armed;
  logic [1:0]       ack_ok;
  logic [1:0]       flags_eff;
  logic             spurious;
  logic             at_check;

  assign cyc_inc = cyc + CNT_W'(1);
  assign ack     = {ack_e2, ack_e1};

  // A channel is armed from its fire cycle onwards, so an ack in the fire cycle itself counts.
  assign armed     = {(cyc >= E2), (cyc >= E1)};
  assign ack_ok    = ack & armed;
  assign spurious  = |(ack & ~armed);
  assign at_check  = (cyc == CHK);
  assign flags_eff = triggered | ack_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cyc        <= '0;
      triggered  <= '0;
      fire_e1    <= 1'b0;
      fire_e2    <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      fail_cause <= CauseNone;
    end else begin
      fire_e1 <= 1'b0;
      fire_e2 <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q    <= StRun;
            cyc        <= '0;
            triggered  <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            fail_cause <= CauseNone;
          end
        end
        StRun: begin
          triggered <= flags_eff;
          if (spurious) begin
            state_q    <= StDone;
            done       <= 1'b1;
            fail       <= 1'b1;
            fail_cause <= CauseSpurious;
          end else if (at_check) begin
            state_q <= StDone;
            done    <= 1'b1;
            if (&flags_eff) begin
              pass <= 1'b1;
            end else begin
              fail       <= 1'b1;
              fail_cause <= CauseMissing;
            end
          end else begin
            // cyc holds on exit so it can never wrap past the check cycle.
            cyc     <= cyc_inc;
            fire_e1 <= (cyc_inc == E1);
            fire_e2 <= (cyc_inc == E2);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_event_seq_checker.sv
// Bench for event_seq_checker: directed and randomized runs checked against a run-level
// reference that derives the verdict from the acknowledgement schedule.
module tb_event_seq_checker;

  localparam int CNT_W     = 8;
  localparam int E1_CYC    = 2;
  localparam int E2_CYC    = 3;
  localparam int CHECK_CYC = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             ack_e1 = 1'b0;
  logic             ack_e2 = 1'b0;
  logic             fire_e1;
  logic             fire_e2;
  logic [CNT_W-1:0] cyc;
  logic [1:0]       triggered;
  logic             done;
  logic             pass;
  logic             fail;
  logic [1:0]       fail_cause;

  int n_chk  = 0;
  int n_pass = 0;

  event_seq_checker #(
    .CNT_W    (CNT_W),
    .E1_CYC   (E1_CYC),
    .E2_CYC   (E2_CYC),
    .CHECK_CYC(CHECK_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ack_e1    (ack_e1),
    .ack_e2    (ack_e2),
    .fire_e1   (fire_e1),
    .fire_e2   (fire_e2),
    .cyc       (cyc),
    .triggered (triggered),
    .done      (done),
    .pass      (pass),
    .fail      (fail),
    .fail_cause(fail_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, ".fire_e1"}, 32'(fire_e1), 0);
    chk({tag, ".fire_e2"}, 32'(fire_e2), 0);
    chk({tag, ".cyc"}, 32'(cyc), 0);
    chk({tag, ".triggered"}, 32'(triggered), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".pass"}, 32'(pass), 0);
    chk({tag, ".fail"}, 32'(fail), 0);
    chk({tag, ".fail_cause"}, 32'(fail_cause), 0);
  endtask

  // One complete run; bit k of m1/m2 is the ack driven during run cycle k.
  task automatic run(input string tag, input logic [CHECK_CYC:0] m1, input logic [CHECK_CYC:0] m2);
    int  last;
    bit  early;
    bit  t1;
    bit  t2;
    bit  ok;
    int  cause;
    // Reference: the first ack ahead of its fire cycle ends the run, else the check cycle does.
    last  = CHECK_CYC;
    early = 1'b0;
    for (int k = 0; k <= CHECK_CYC; k++) begin
      if (!early && ((m1[k] && k < E1_CYC) || (m2[k] && k < E2_CYC))) begin
        early = 1'b1;
        last  = k;
      end
    end
    t1 = 1'b0;
    t2 = 1'b0;
    for (int k = 0; k <= last; k++) begin
      if (m1[k] && k >= E1_CYC) t1 = 1'b1;
      if (m2[k] && k >= E2_CYC) t2 = 1'b1;
    end
    ok    = !early && t1 && t2;
    cause = early ? 1 : (ok ? 0 : 2);

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= last; k++) begin
      bit s1;
      bit s2;
      s1 = 1'b0;
      s2 = 1'b0;
      for (int j = 0; j < k; j++) begin
        if (m1[j] && j >= E1_CYC) s1 = 1'b1;
        if (m2[j] && j >= E2_CYC) s2 = 1'b1;
      end
      chk({tag, ".run.cyc"}, 32'(cyc), 32'(k));
      chk({tag, ".run.fire_e1"}, 32'(fire_e1), 32'(k == E1_CYC));
      chk({tag, ".run.fire_e2"}, 32'(fire_e2), 32'(k == E2_CYC));
      chk({tag, ".run.triggered"}, 32'(triggered), 32'({s2, s1}));
      chk({tag, ".run.verdict"}, 32'({done, pass, fail, fail_cause}), 0);
      ack_e1 = m1[k];
      ack_e2 = m2[k];
      tick();
    end
    ack_e1 = 1'b0;
    ack_e2 = 1'b0;

    // Verdict, then it must hold while acks are ignored in DONE.
    for (int h = 0; h < 3; h++) begin
      chk({tag, ".done"}, 32'(done), 1);
      chk({tag, ".pass"}, 32'(pass), 32'(ok));
      chk({tag, ".fail"}, 32'(fail), 32'(!ok));
      chk({tag, ".fail_cause"}, 32'(fail_cause), 32'(cause));
      chk({tag, ".cyc_hold"}, 32'(cyc), 32'(last));
      chk({tag, ".triggered_hold"}, 32'(triggered), 32'({t2, t1}));
      chk({tag, ".fires_quiet"}, 32'({fire_e2, fire_e1}), 0);
      ack_e1 = 1'($urandom_range(0, 1));
      ack_e2 = 1'($urandom_range(0, 1));
      tick();
    end
    ack_e1 = 1'b0;
    ack_e2 = 1'b0;
  endtask

  initial begin
    logic [CHECK_CYC:0] r1;
    logic [CHECK_CYC:0] r2;

    #1 rst_n = 1'b0;
    #1 check_cleared("reset");
    tick();
    tick();
    rst_n = 1'b1;

    // Acks in IDLE are ignored.
    ack_e1 = 1'b1;
    ack_e2 = 1'b1;
    tick();
    tick();
    ack_e1 = 1'b0;
    ack_e2 = 1'b0;
    tick();
    check_cleared("idle_acks");

    run("nominal", 5'b00100, 5'b10000);
    run("missing", 5'b00100, 5'b00000);
    run("restart", 5'b00100, 5'b10000);
    run("spurious", 5'b00000, 5'b00010);
    run("late_valid", 5'b01000, 5'b10000);
    run("both_early", 5'b00001, 5'b00001);
    run("fire_cycle_acks", 5'b00100, 5'b01000);
    run("level_acks", 5'b11100, 5'b11000);

    // Reset mid-run while fire_e2 is high.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    ack_e1 = 1'b1;
    tick();
    ack_e1 = 1'b0;
    chk("midrun.cyc", 32'(cyc), 3);
    chk("midrun.fire_e2", 32'(fire_e2), 1);
    chk("midrun.triggered", 32'(triggered), 1);
    #1 rst_n = 1'b0;
    #1 check_cleared("midrun_reset");
    tick();
    rst_n = 1'b1;
    tick();
    check_cleared("after_reset");
    run("post_reset", 5'b00100, 5'b10000);

    for (int i = 0; i < 30; i++) begin
      r1 = 5'($urandom_range(0, 31));
      r2 = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) r1 &= 5'b11100;
      if ($urandom_range(0, 3) != 0) r2 &= 5'b11000;
      run("random", r1, r2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
